// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel-enable divider, h/v timing
// counters, four selectable patterns and a bouncing box. All outputs are
// registered on the pixel enable so colour, sync, blank and col/row line up.
module vga_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4,
  parameter int BOX_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_L,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [9:0]         col,
  output logic [9:0]         row,
  output logic               blank,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW      = 10 + COLOR_W;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]         H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]         V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]         H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]         V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]         HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]         HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]         VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]         VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]         BAR_W    = 10'(H_ACTIVE / 8);
  localparam logic [9:0]         X_MAX    = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]         Y_MAX    = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]         BOX_W    = 10'(BOX_SIZE);
  localparam logic [GW-1:0]      GRAD_DIV = GW'(H_ACTIVE);
  localparam logic [COLOR_W-1:0] MAX      = '1;

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_en;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               h_wrap;
  logic               frame_wrap;
  logic [1:0]         mode_q;
  logic [9:0]         box_x;
  logic [9:0]         box_y;
  logic               dir_x;
  logic               dir_y;
  logic               active;
  logic               in_box;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] grad;
  logic [COLOR_W-1:0] pat_r;
  logic [COLOR_W-1:0] pat_g;
  logic [COLOR_W-1:0] pat_b;

  assign pix_en     = (div_cnt == DIV_LAST);
  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_wrap = pix_en && h_wrap && (v_cnt == V_LAST);
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Divider producing one pixel enable every CLK_DIV system clocks.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)      div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // Horizontal and vertical timing counters, advanced on the pixel enable.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Frame-boundary bookkeeping: pattern select, frame counter and start pulse.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      mode_q      <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        mode_q    <= mode;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Bouncing box: one step per frame per axis, reversing at either edge.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_wrap) begin
      if (dir_x) begin
        if (box_x == X_MAX) begin
          dir_x <= 1'b0;
          box_x <= box_x - 10'd1;
        end else begin
          box_x <= box_x + 10'd1;
        end
      end else if (box_x == 10'd0) begin
        dir_x <= 1'b1;
        box_x <= box_x + 10'd1;
      end else begin
        box_x <= box_x - 10'd1;
      end
      if (dir_y) begin
        if (box_y == Y_MAX) begin
          dir_y <= 1'b0;
          box_y <= box_y - 10'd1;
        end else begin
          box_y <= box_y + 10'd1;
        end
      end else if (box_y == 10'd0) begin
        dir_y <= 1'b1;
        box_y <= box_y + 10'd1;
      end else begin
        box_y <= box_y - 10'd1;
      end
    end
  end

  // Pattern colour for the current counter position under the latched mode.
  always_comb begin
    pat_r   = '0;
    pat_g   = '0;
    pat_b   = '0;
    bar_idx = 3'(h_cnt / BAR_W);
    grad    = COLOR_W'({h_cnt, {COLOR_W{1'b0}}} / GRAD_DIV);
    in_box  = (h_cnt >= box_x) && (h_cnt < box_x + BOX_W) &&
              (v_cnt >= box_y) && (v_cnt < box_y + BOX_W);
    case (mode_q)
      2'd0: begin
        pat_r = {COLOR_W{bar_idx[2]}};
        pat_g = {COLOR_W{bar_idx[1]}};
        pat_b = {COLOR_W{bar_idx[0]}};
      end
      2'd1: begin
        if (h_cnt[5] ^ v_cnt[5]) begin
          pat_r = MAX;
          pat_g = MAX;
          pat_b = MAX;
        end
      end
      2'd2: begin
        pat_r = grad;
        pat_g = grad;
        pat_b = grad;
      end
      default: begin
        pat_b = MAX;
        if (in_box) begin
          pat_r = MAX;
          pat_g = MAX;
        end
      end
    endcase
  end

  // Output register: loads the pre-increment pixel so everything stays aligned.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      col    <= '0;
      row    <= '0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      blank  <= 1'b0;
    end else if (pix_en) begin
      col    <= h_cnt;
      row    <= v_cnt;
      VGA_R  <= active ? pat_r : '0;
      VGA_G  <= active ? pat_g : '0;
      VGA_B  <= active ? pat_b : '0;
      VGA_HS <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      VGA_VS <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      blank  <= !active;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen using a shrunken timing so several
// frames fit in a short run: 48x40 total, 40x36 active, CLK_DIV=2, box 34.
module tb_vga_pattern_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 40;
  localparam int V_ACTIVE = 36;

  logic        clk;
  logic        rst_L;
  logic [1:0]  mode;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        blank;
  logic        frame_start;
  logic [15:0] frame_cnt;

  typedef struct {
    int         f;
    int         c;
    int         r;
    logic [14:0] pix;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fails    = 0;
  int   cycle      = 0;
  int   pulse_cnt  = 0;
  int   long_pulse = 0;
  logic prev_fs    = 1'b0;

  vga_pattern_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(V_ACTIVE), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_W(4), .BOX_SIZE(34)
  ) dut (
    .clk(clk), .rst_L(rst_L), .mode(mode),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .col(col), .row(row), .blank(blank),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the latest reset release; edge 2*(f*1920+v*48+h)+2 shows pixel (h,v) of frame f.
  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) cycle <= 0;
    else        cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic expect_pixel(input int f, input int c, input int r,
                              input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb,
                              input logic hs, input logic vs, input logic bl);
    exp_t e;
    e.f   = f;
    e.c   = c;
    e.r   = r;
    e.pix = {rr, gg, bb, hs, vs, bl};
    sb.push_back(e);
  endtask

  task automatic wait_cycle(input int target);
    while (cycle < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input int target);
    wait_cycle(target);
    mode = m;
    $display("[TB] mode -> %0d at cycle %0d", m, cycle);
  endtask

  // Monitor: pops the head expectation when the DUT presents that frame/col/row.
  always @(negedge clk) begin
    if (rst_L) begin
      if (frame_start) begin
        pulse_cnt++;
        checkOutput("fs_on_wrap_pixel", {12'd0, col, row}, {12'd0, 10'd47, 10'd39});
      end
      if (frame_start && prev_fs) long_pulse++;
      prev_fs = frame_start;
      if (sb.size() > 0) begin
        if (int'(frame_cnt) == sb[0].f && int'(col) == sb[0].c && int'(row) == sb[0].r) begin
          checkOutput($sformatf("pix_f%0d_c%0d_r%0d", sb[0].f, sb[0].c, sb[0].r),
                      {17'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, blank},
                      {17'd0, sb[0].pix});
          void'(sb.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus: queue expectations, then reset, mode changes and final checks.
  initial begin
    rst_L = 1'b0;
    mode  = 2'd0;

    // frame 0: colour bars, sync and blank boundaries
    expect_pixel(0,  4,  0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(0,  5,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(0, 20,  0, 4'hF, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(0, 39,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(0, 40,  0, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    expect_pixel(0, 42,  0, 4'h0, 4'h0, 4'h0, 0, 1, 1);
    expect_pixel(0, 45,  0, 4'h0, 4'h0, 4'h0, 0, 1, 1);
    expect_pixel(0, 46,  0, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    expect_pixel(0, 10, 20, 4'h0, 4'hF, 4'h0, 1, 1, 0);
    expect_pixel(0, 39, 35, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(0,  0, 36, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    expect_pixel(0,  0, 37, 4'h0, 4'h0, 4'h0, 1, 0, 1);
    expect_pixel(0, 47, 38, 4'h0, 4'h0, 4'h0, 1, 0, 1);
    expect_pixel(0,  0, 39, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    // frame 1: checkerboard
    expect_pixel(1, 31,  0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(1, 32,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(1, 10, 20, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(1,  0, 32, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(1, 32, 32, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    // frame 2: gradient, col*16/40
    expect_pixel(2,  0,  0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(2,  2,  0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    expect_pixel(2,  3,  0, 4'h1, 4'h1, 4'h1, 1, 1, 0);
    expect_pixel(2, 39,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(2, 20,  5, 4'h8, 4'h8, 4'h8, 1, 1, 0);
    expect_pixel(2, 40,  5, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    // frame 3: box at (3,1)
    expect_pixel(3,  3,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(3,  2,  1, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(3,  3,  1, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(3, 39, 10, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(3, 36, 34, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(3, 37, 34, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(3,  3, 35, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    // frame 4: box at (4,0), y bounced off its maximum
    expect_pixel(4,  3,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(4,  4,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(4, 37, 33, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(4, 38, 33, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(4,  4, 34, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    // frame 5: box at (5,1), y bounced off zero
    expect_pixel(5,  5,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(5,  4,  1, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(5,  5,  1, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    // frame 6: box at (6,2), x at its maximum
    expect_pixel(6,  6,  1, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(6,  5,  2, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(6,  6,  2, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(6, 39, 35, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    // frame 7: box at (5,1), x reversed
    expect_pixel(7,  4,  1, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(7,  5,  1, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(7, 38,  1, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(7, 39,  1, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    // frame 8: box at (4,0)
    expect_pixel(8,  3,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);
    expect_pixel(8,  4,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(8, 37,  0, 4'hF, 4'hF, 4'hF, 1, 1, 0);
    expect_pixel(8, 38,  0, 4'h0, 4'h0, 4'hF, 1, 1, 0);

    // reset state while held
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pix", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    checkOutput("rst_sync", {29'd0, vga_hs, vga_vs, blank}, {29'd0, 3'b110});
    checkOutput("rst_colrow", {12'd0, col, row}, 32'd0);
    checkOutput("rst_frame", {15'd0, frame_start, frame_cnt}, 32'd0);

    // first pixel appears CLK_DIV clocks after release; col advances at edge 4
    @(negedge clk);
    rst_L = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("first_col_e%0d", e), {22'd0, col}, (e == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("first_out_e%0d", e),
                  {17'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, blank}, {17'd0, 15'b110});
    end

    // mode changes mid-frame; each applies from the following frame
    applyStimulus(2'd1, 962);
    applyStimulus(2'd2, 4322);
    applyStimulus(2'd3, 8162);

    // wait for the scoreboard to drain, bounded
    while (sb.size() > 0 && cycle < 40000) @(negedge clk);
    checkOutput("scoreboard_drain", sb.size(), 32'd0);

    // frame counting at pixel (43,5) of frame 9
    wait_cycle(35128);
    checkOutput("frame_cnt", {16'd0, frame_cnt}, 32'd9);
    checkOutput("frame_cnt_vs_pulses", {16'd0, frame_cnt}, pulse_cnt);
    checkOutput("fs_width", long_pulse, 32'd0);

    // asynchronous reset mid-line (HS low, blanked region)
    #1;
    rst_L = 1'b0;
    #1;
    checkOutput("midrst_pix", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    checkOutput("midrst_sync", {29'd0, vga_hs, vga_vs, blank}, {29'd0, 3'b110});
    checkOutput("midrst_colrow", {12'd0, col, row}, 32'd0);
    checkOutput("midrst_frame", {15'd0, frame_start, frame_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator for bring-up of the VDP video path. It derives a pixel enable from the board clock, runs its own horizontal and vertical timing counters, and drives registered RGB and sync outputs straight to the VGA pins. It offers four selectable patterns: colour bars, checkerboard, grey gradient and a bouncing box. The mode is switched glitch-free on frame boundaries, so timing, bars and motion can all be checked on a monitor or in simulation.

## Interface
- CLK_DIV, 4: system clocks per pixel (≥1); 100 MHz gives 25 MHz pixel rate.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- COLOR_W, 4: bits per colour channel.
- BOX_SIZE, 32: bouncing-box edge length in pixels.
- clk  in  1  system clock; everything runs on posedge clk.
- rst_L  in  1  asynchronous, active-low reset.
- mode  in  2  pattern select; sampled only at frame wrap.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour; zero while blanked.
- VGA_HS, VGA_VS  out  1 each  syncs, active low.
- col  out  10  horizontal count of the pixel currently driven.
- row  out  10  vertical count of the pixel currently driven.
- blank  out  1  high when the driven pixel is outside the active area.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).
- frame_cnt  out  16  frames started since reset; wraps.

## Operation
**Pixel enable**
- Divider counts 0..CLK_DIV-1; `pix_en` is asserted when the divider equals CLK_DIV-1.
- With CLK_DIV=1, `pix_en` is asserted every cycle.

**Timing counters**
- On `pix_en`, h_cnt increments, wrapping at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1.
- v_cnt increments on h wrap and wraps at V_TOTAL-1.

**Output register**
- On each `pix_en` edge, all outputs load the values for the pre-increment (h_cnt, v_cnt).
- col, row, colours, HS, VS and blank are therefore mutually aligned.
- HS is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VS is low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- blank = (h ≥ H_ACTIVE) or (v ≥ V_ACTIVE).

**Frame wrap** (`pix_en` with h = H_TOTAL-1 and v = V_TOTAL-1)
- mode_q <= mode.
- frame_cnt increments.
- frame_start pulses for exactly one clk.
- The box position steps.

**Patterns** (active area only; MAX = all ones)
- 0, bars: idx = col/(H_ACTIVE/8). R = idx[2], G = idx[1], B = idx[0], each channel either MAX or 0.
- 1, checker: white when col[5]^row[5], else black.
- 2, gradient: all channels = (col·2^COLOR_W)/H_ACTIVE, giving 0..MAX left to right.
- 3, box: white inside [box_x, box_x+BOX_SIZE) × [box_y, box_y+BOX_SIZE); blue MAX elsewhere.

**Box motion**
- Per axis: a position plus a direction bit.
- Reset state: position (0,0), both directions +.
- At each frame wrap, step ±1 per axis.
- x at H_ACTIVE-BOX_SIZE with dir + → dir becomes −, x decrements. Same rule for y with V_ACTIVE.
- At 0 with dir − → dir becomes +, position increments.
- Motion runs in every mode.

**Reset values**
- Divider, counters, col, row, colours, frame_cnt and mode_q: 0.
- HS = VS = 1, blank = 0, frame_start = 0.
- Box at (0,0), directions +.
- Reset asserted mid-frame returns everything to these values immediately, with no partial line.

## Timing
- Pixel period: CLK_DIV clocks.
- Line: H_TOTAL·CLK_DIV clocks, 3200 at defaults.
- Frame: V_TOTAL lines, 525 at defaults.
- First `pix_en` is CLK_DIV clocks after reset release; outputs then show pixel (0,0).
- Output latency: one `pix_en` edge from counter state.
- Outputs are stable for CLK_DIV clocks between `pix_en` edges.
- mode change latency: it takes effect at the first pixel of the frame after the next wrap. A change mid-frame never alters the current frame.
- frame_start rises on the same clk edge as the counter wrap.

## Test plan
- **Reset and first pixel:** release rst_L, run with defaults. Expect HS=VS=1, colours 0 for 3 clks; at clk 4, col=0, row=0, blank=0. Assert rst_L mid-line and expect all outputs back at reset values asynchronously.
- **Sync timing:**
  - HS period is 3200 clks, low for 384 clks, falling edge 2624 clks after col=0.
  - VS low for 2 lines (6400 clks), starting at row 490.
  - blank high for col 640..799 and row 480..524.
- **Colour bars (mode=0):**
  - col 79 → RGB=(0,0,0); col 80 → (0,0,F); col 320 → (F,0,0); col 639 → (F,F,F).
  - Colours are 0 at col 640.
- **Mode switching:** with mode=0, change to 1 at row 100. Rest of the frame stays bars. The next frame shows checker: (col 32, row 0) white, (col 32, row 32) black.
- **Gradient (mode=2):** col 0 → 0, col 40 → 1, col 639 → F on all channels.
- **Bouncing box (mode=3):**
  - Frame 0: box at (0,0), so pixel (31,31) is white and (32,0) is blue.
  - After 448 wraps: y=448 and flipping; next frame y=447.
  - x reaches 608 at frame 608; frame 609 has x=607.
  - frame_cnt equals the number of frame_start pulses.
